reg_file: RTL and testbench

Architectural register file with rename tags: the consumer of the reorder buffer's commit stream and the source of operand/dependency lookups for dispatch. It holds 32 × XLEN values plus, per register, the ROB alias of the youngest in-flight producer (0 = value is architectural and ready). Dispatch renames destinations here, the ROB retires results here, and a rollback drops every pending tag in one cycle.

---
 rtl/reg_file_pkg.sv | 45 ++++
 rtl/reg_file_if.sv | 44 ++++
 rtl/reg_file.sv | 54 +++++
 tb/tb_reg_file.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared types for the architectural register file: widths, rename-tag
// encoding (alias 0 = no dependency) and the read-port lookup with commit bypass.
package reg_file_pkg;

   localparam int XLEN      = 32;
   localparam int ROB_WIDTH = 4;
   localparam int NREG      = 32;
   localparam int REG_WIDTH = $clog2(NREG);

   typedef logic [XLEN-1:0]      data_t;
   typedef logic [ROB_WIDTH-1:0] alias_t;
   typedef logic [REG_WIDTH-1:0] reg_id_t;

   localparam alias_t NO_DEP = '0;

   typedef struct packed {
      data_t  value;
      alias_t tag;
   } read_t;

   // A retiring producer whose alias still owns the register is forwarded
   // directly, so dispatch never sees a tag that is resolving this very cycle.
   function automatic read_t lookup(
      input reg_id_t id,
      input data_t   stored_value,
      input alias_t  stored_tag,
      input logic    commit_valid,
      input reg_id_t commit_rd,
      input alias_t  commit_alias,
      input data_t   commit_value
   );
      read_t r;
      r.value = stored_value;
      r.tag   = stored_tag;
      if (id == '0) begin
         r.value = '0;
         r.tag   = NO_DEP;
      end else if (commit_valid && commit_rd == id && stored_tag == commit_alias) begin
         r.value = commit_value;
         r.tag   = NO_DEP;
      end
      return r;
   endfunction

endpackage

// File: rtl/reg_file_if.sv
// Bus between dispatch/ROB (master) and the register file (slave): commit
// stream, rename stream, rollback and the two combinational read ports.
interface reg_file_if;
   import reg_file_pkg::*;

   // rdy is a global enable, not a handshake: when low, commit/rename/rollback
   // presented that cycle are ignored and the producer must hold them; there is
   // no back-pressure otherwise, one commit and one rename are taken every cycle.
   logic    rdy;
   logic    rollback;

   logic    commit_valid;
   reg_id_t commit_rd;
   alias_t  commit_alias;
   data_t   commit_value;

   logic    rename_valid;
   reg_id_t rename_rd;
   alias_t  rename_alias;

   reg_id_t rs1_id;
   reg_id_t rs2_id;
   data_t   rs1_value;
   data_t   rs2_value;
   alias_t  rs1_tag;
   alias_t  rs2_tag;

   modport master (
      output rdy, rollback,
      output commit_valid, commit_rd, commit_alias, commit_value,
      output rename_valid, rename_rd, rename_alias,
      output rs1_id, rs2_id,
      input  rs1_value, rs2_value, rs1_tag, rs2_tag
   );

   modport slave (
      input  rdy, rollback,
      input  commit_valid, commit_rd, commit_alias, commit_value,
      input  rename_valid, rename_rd, rename_alias,
      input  rs1_id, rs2_id,
      output rs1_value, rs2_value, rs1_tag, rs2_tag
   );

endinterface

// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags: retires ROB
// results, records dispatch renames, drops all tags on rollback.
module reg_file
   import reg_file_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   reg_file_if.slave  bus
);

   data_t  value_q [NREG];
   alias_t tag_q   [NREG];

   read_t  rs1_rd;
   read_t  rs2_rd;

   // x0 is never written, so entry 0 stays at its reset value of zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            value_q[i] <= '0;
            tag_q[i]   <= NO_DEP;
         end
      end else if (bus.rdy) begin
         for (int i = 1; i < NREG; i++) begin
            if (bus.commit_valid && bus.commit_rd == reg_id_t'(i)) begin
               value_q[i] <= bus.commit_value;
            end
            // Rollback beats rename; rename beats commit since it is the younger producer.
            if (bus.rollback) begin
               tag_q[i] <= NO_DEP;
            end else if (bus.rename_valid && bus.rename_rd == reg_id_t'(i)) begin
               tag_q[i] <= bus.rename_alias;
            end else if (bus.commit_valid && bus.commit_rd == reg_id_t'(i) &&
                         tag_q[i] == bus.commit_alias) begin
               tag_q[i] <= NO_DEP;
            end
         end
      end
   end

   always_comb begin
      rs1_rd = lookup(bus.rs1_id, value_q[bus.rs1_id], tag_q[bus.rs1_id],
                      bus.commit_valid, bus.commit_rd, bus.commit_alias, bus.commit_value);
      rs2_rd = lookup(bus.rs2_id, value_q[bus.rs2_id], tag_q[bus.rs2_id],
                      bus.commit_valid, bus.commit_rd, bus.commit_alias, bus.commit_value);
   end

   assign bus.rs1_value = rs1_rd.value;
   assign bus.rs1_tag   = rs1_rd.tag;
   assign bus.rs2_value = rs2_rd.value;
   assign bus.rs2_tag   = rs2_rd.tag;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, x0, rename/commit ordering, bypass,
// rollback, rdy freeze and asynchronous reset.
module tb_reg_file;
   import reg_file_pkg::*;

   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   reg_file_if bus ();

   reg_file u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // driver tasks
   task automatic clear_inputs();
      bus.rdy          = 1'b1;
      bus.rollback     = 1'b0;
      bus.commit_valid = 1'b0;
      bus.commit_rd    = '0;
      bus.commit_alias = '0;
      bus.commit_value = '0;
      bus.rename_valid = 1'b0;
      bus.rename_rd    = '0;
      bus.rename_alias = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic commit(input reg_id_t rd, input alias_t a, input data_t v);
      bus.commit_valid = 1'b1;
      bus.commit_rd    = rd;
      bus.commit_alias = a;
      bus.commit_value = v;
   endtask

   task automatic rename(input reg_id_t rd, input alias_t a);
      bus.rename_valid = 1'b1;
      bus.rename_rd    = rd;
      bus.rename_alias = a;
   endtask

   // checking
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reg(input string tag, input reg_id_t id, input data_t v, input alias_t t);
      bus.rs1_id = id;
      bus.rs2_id = id;
      #1;
      check({tag, ".rs1_value"}, bus.rs1_value, v);
      check({tag, ".rs1_tag"},   32'(bus.rs1_tag), 32'(t));
      check({tag, ".rs2_value"}, bus.rs2_value, v);
      check({tag, ".rs2_tag"},   32'(bus.rs2_tag), 32'(t));
   endtask

   // directed sequence
   initial begin
      rst_n = 1'b0;
      clear_inputs();
      bus.rs1_id = '0;
      bus.rs2_id = '0;
      #2;
      check_reg("in_reset_x5", 5'd5, 32'h0, 4'd0);
      #10 rst_n = 1'b1;

      for (int i = 0; i < NREG; i++) begin
         check_reg($sformatf("reset_x%0d", i), reg_id_t'(i), 32'h0, 4'd0);
      end

      // x0 ignores commits and is never bypassed
      tick();
      commit(5'd0, 4'd0, 32'hDEAD);
      check_reg("x0_commit_bypass", 5'd0, 32'h0, 4'd0);
      tick();
      clear_inputs();
      check_reg("x0_after_commit", 5'd0, 32'h0, 4'd0);

      // rename then commit with same-cycle bypass
      rename(5'd5, 4'd3);
      check_reg("x5_no_rename_visible", 5'd5, 32'h0, 4'd0);
      tick();
      clear_inputs();
      check_reg("x5_renamed", 5'd5, 32'h0, 4'd3);
      commit(5'd5, 4'd3, 32'h1234);
      check_reg("x5_bypass", 5'd5, 32'h1234, 4'd0);
      tick();
      clear_inputs();
      check_reg("x5_committed", 5'd5, 32'h1234, 4'd0);

      // older commit must not clear a younger producer's tag
      rename(5'd5, 4'd3);
      tick();
      rename(5'd5, 4'd7);
      tick();
      clear_inputs();
      check_reg("x5_tag7", 5'd5, 32'h1234, 4'd7);
      commit(5'd5, 4'd3, 32'h11);
      check_reg("x5_stale_no_bypass", 5'd5, 32'h1234, 4'd7);
      tick();
      clear_inputs();
      check_reg("x5_stale_commit", 5'd5, 32'h11, 4'd7);
      commit(5'd5, 4'd7, 32'h22);
      check_reg("x5_young_bypass", 5'd5, 32'h22, 4'd0);
      tick();
      clear_inputs();
      check_reg("x5_young_commit", 5'd5, 32'h22, 4'd0);

      // same-cycle commit and rename of one register: rename owns the tag
      rename(5'd6, 4'd2);
      tick();
      clear_inputs();
      commit(5'd6, 4'd2, 32'hAA);
      rename(5'd6, 4'd9);
      check_reg("x6_bypass_pre_rename", 5'd6, 32'hAA, 4'd0);
      tick();
      clear_inputs();
      check_reg("x6_rename_wins", 5'd6, 32'hAA, 4'd9);

      // rollback clears every tag, keeps commit value, drops rename
      rename(5'd1, 4'd1);
      tick();
      rename(5'd2, 4'd2);
      tick();
      rename(5'd3, 4'd3);
      tick();
      clear_inputs();
      check_reg("x3_pre_rollback", 5'd3, 32'h0, 4'd3);
      bus.rollback = 1'b1;
      commit(5'd4, 4'd6, 32'h55);
      rename(5'd7, 4'd5);
      tick();
      clear_inputs();
      check_reg("rb_x1", 5'd1, 32'h0, 4'd0);
      check_reg("rb_x2", 5'd2, 32'h0, 4'd0);
      check_reg("rb_x3", 5'd3, 32'h0, 4'd0);
      check_reg("rb_x4", 5'd4, 32'h55, 4'd0);
      check_reg("rb_x6", 5'd6, 32'hAA, 4'd0);
      check_reg("rb_x7", 5'd7, 32'h0, 4'd0);

      // rdy low freezes state, including rollback
      rename(5'd9, 4'd4);
      tick();
      clear_inputs();
      bus.rdy = 1'b0;
      commit(5'd8, 4'd1, 32'h99);
      rename(5'd9, 4'd12);
      bus.rollback = 1'b1;
      tick();
      clear_inputs();
      check_reg("frozen_x8", 5'd8, 32'h0, 4'd0);
      check_reg("frozen_x9", 5'd9, 32'h0, 4'd4);
      check_reg("frozen_x5", 5'd5, 32'h22, 4'd0);

      // asynchronous reset between edges
      rst_n = 1'b0;
      check_reg("async_rst_x4", 5'd4, 32'h0, 4'd0);
      check_reg("async_rst_x9", 5'd9, 32'h0, 4'd0);
      rst_n = 1'b1;
      tick();
      check_reg("post_rst_x6", 5'd6, 32'h0, 4'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
